// File: rtl/approx_mul_acc.sv
// Saturating accumulator for the approx_mul product stream.
// A run sums a programmed number of 32-bit products into an ACC_W-bit register
// that clamps at all-ones, then offers the sum over a valid/ready handshake.
module approx_mul_acc #(
  parameter int unsigned ACC_W = 40,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             prod_valid_i,
  input  logic [31:0]      prod_in_i,
  output logic             prod_ready_o,
  output logic [ACC_W-1:0] acc_out_o,
  output logic             acc_valid_o,
  input  logic             acc_ready_i,
  output logic             busy_o,
  output logic             ovf_o
);

  typedef enum logic [1:0] {StIdle = 2'd0, StAcc = 2'd1, StDone = 2'd2} state_e;

  state_e           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [LEN_W-1:0] cnt_q;
  logic             ovf_q;

  // One guard bit above the accumulator catches the carry that signals saturation.
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_add;
  logic             sat;

  // Widened add of the current product and its clamped result.
  always_comb begin
    sum     = {1'b0, acc_q} + {{(ACC_W + 1 - 32){1'b0}}, prod_in_i};
    sat     = sum[ACC_W];
    acc_add = sat ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
  end

  // Run control FSM together with the accumulator, product counter and sticky overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= len_i;
            // An empty run has nothing to wait for; its sum of zero is ready at once.
            state_q <= (len_i == '0) ? StDone : StAcc;
          end
        end
        StAcc: begin
          if (prod_valid_i) begin
            acc_q <= acc_add;
            if (sat) ovf_q <= 1'b1;
            cnt_q <= cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) state_q <= StDone;
          end
        end
        StDone: begin
          if (acc_ready_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Handshake and status outputs decode straight from the registered state.
  always_comb begin
    prod_ready_o = (state_q == StAcc);
    acc_valid_o  = (state_q == StDone);
    busy_o       = (state_q == StAcc) || (state_q == StDone);
    acc_out_o    = acc_q;
    ovf_o        = ovf_q;
  end

endmodule
